// File: rtl/mux2to1_arbiter.sv
// Two-requester round-robin arbiter that steers one shared operand mux
// and presents the captured operand downstream over valid/ready.

module mux2to1_nbits #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            sel,
    output logic [SIZE-1:0] y
);
    assign y = sel ? a : b;
endmodule

module mux2to1_arbiter #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_a,
    input  logic [SIZE-1:0] data_a,
    input  logic            req_b,
    input  logic [SIZE-1:0] data_b,
    output logic            ack_a,
    output logic            ack_b,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            owner
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic            prio;
    logic            grant_a;
    logic            grant_any;
    logic [SIZE-1:0] mux_y;

    // A lone request wins outright; prio only breaks ties.
    always_comb begin
        grant_any = req_a | req_b;
        grant_a   = req_a & (~req_b | prio);
    end

    mux2to1_nbits #(.SIZE(SIZE)) u_mux (
        .a   (data_a),
        .b   (data_b),
        .sel (grant_a),
        .y   (mux_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b1;
            out_data  <= '0;
            owner     <= 1'b0;
            out_valid <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (grant_any) begin
                        out_data  <= mux_y;
                        owner     <= grant_a;
                        out_valid <= 1'b1;
                        ack_a     <= grant_a;
                        ack_b     <= ~grant_a;
                        prio      <= ~grant_a;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Randomized bench for mux2to1_arbiter against a transaction-level
// round-robin model, plus directed reset and 8-bit width cases.

module tb_mux2to1_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
    logic [3:0] data_a = '0, data_b = '0;
    logic       ack_a, ack_b, out_valid, owner;
    logic [3:0] out_data;

    logic       req_a8 = 1'b0, req_b8 = 1'b0;
    logic [7:0] data_a8 = 8'hA5, data_b8 = 8'h3C;
    logic       ack_a8, ack_b8, out_valid8, owner8;
    logic [7:0] out_data8;

    int checks = 0;
    int errors = 0;

    // Model: a pending operand slot plus the identity of the last winner.
    logic       e_valid, e_owner, e_acka, e_ackb, last_a;
    logic [3:0] e_data;

    always #5 clk = ~clk;

    mux2to1_arbiter #(.SIZE(4)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .ack_a(ack_a), .ack_b(ack_b), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .owner(owner)
    );

    mux2to1_arbiter #(.SIZE(8)) dut8 (
        .clk(clk), .reset(reset),
        .req_a(req_a8), .data_a(data_a8), .req_b(req_b8), .data_b(data_b8),
        .ack_a(ack_a8), .ack_b(ack_b8), .out_data(out_data8),
        .out_valid(out_valid8), .out_ready(1'b1), .owner(owner8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        e_owner = 1'b0;
        e_acka  = 1'b0;
        e_ackb  = 1'b0;
        e_data  = '0;
        last_a  = 1'b0;
    endtask

    // Predict the edge from current inputs, advance one clock, compare.
    task automatic step();
        logic win_a;
        e_acka = 1'b0;
        e_ackb = 1'b0;
        if (e_valid) begin
            if (out_ready) e_valid = 1'b0;
        end else if (req_a || req_b) begin
            if (req_a && req_b) win_a = !last_a;
            else                win_a = req_a;
            last_a  = win_a;
            e_valid = 1'b1;
            e_owner = win_a;
            e_data  = win_a ? data_a : data_b;
            e_acka  = win_a;
            e_ackb  = !win_a;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, e_valid);
        check("owner", owner, e_owner);
        check("out_data", out_data, e_data);
        check("ack_a", ack_a, e_acka);
        check("ack_b", ack_b, e_ackb);
        check("ack_excl", ack_a & ack_b, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_owner", owner, 0);
        check("rst_acks", {ack_a, ack_b}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Lone A.
        data_a = 4'h5; req_a = 1'b1; out_ready = 1'b1;
        step();
        check("loneA_valid", out_valid, 1);
        check("loneA_data", out_data, 4'h5);
        check("loneA_owner", owner, 1);
        check("loneA_ack", ack_a, 1);
        req_a = 1'b0;
        step();
        check("loneA_done", out_valid, 0);
        check("loneA_ackoff", ack_a, 0);

        // Capture B (prio now favours B), backpressure, then reset mid-HOLD.
        data_b = 4'h9; req_b = 1'b1; out_ready = 1'b0;
        step();
        check("holdB_data", out_data, 4'h9);
        req_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_b = 4'($urandom);
            req_a  = 1'($urandom);
            step();
            check("bp_data", out_data, 4'h9);
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_owner", owner, 0);
        check("arst_acks", {ack_a, ack_b}, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Both requesting continuously: 3,9,3,9 with A first after reset.
        data_a = 4'h3; data_b = 4'h9; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
        step();
        check("alt_first_owner", owner, 1);
        check("alt_first_data", out_data, 4'h3);
        for (int i = 0; i < 7; i++) step();
        check("alt_last_data", out_data, 4'h9);

        // Random requesters honouring the ack / operand-stability rule.
        for (int i = 0; i < 400; i++) begin
            if (e_acka) begin
                req_a = 1'($urandom);
                data_a = 4'($urandom);
            end else if (!req_a && $urandom_range(0, 9) < 4) begin
                req_a = 1'b1;
                data_a = 4'($urandom);
            end
            if (e_ackb) begin
                req_b = 1'($urandom);
                data_b = 4'($urandom);
            end else if (!req_b && $urandom_range(0, 9) < 4) begin
                req_b = 1'b1;
                data_b = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        // Full-width 8-bit instance, never granted before, so A wins first.
        req_a8 = 1'b1; req_b8 = 1'b1;
        @(posedge clk); #1;
        check("w8_first_data", out_data8, 8'hA5);
        check("w8_first_owner", owner8, 1);
        check("w8_first_ack", {ack_a8, ack_b8}, 2'b10);
        @(posedge clk); #1;
        check("w8_xfer", out_valid8, 0);
        @(posedge clk); #1;
        check("w8_second_data", out_data8, 8'h3C);
        check("w8_second_owner", owner8, 0);
        check("w8_second_ack", {ack_a8, ack_b8}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
